reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Sequential producer side of the ID-stage hazard check: tracks which architectural registers have writes in flight between ID/EXE issue and WB retire.
- Per register it holds a pending-write counter and a one-cycle "load in EXE" flag.
- It answers src1/src2 queries for the instruction in ID and drives hazard/stall to the pipeline-freeze logic.
- Sits beside the ID stage, fed by the issue point and the WB stage.

Parameters:
- NREG, 16, number of architectural registers
- REG_W, 4, register index width (log2 NREG)
- CNT_W, 2, pending counter width; max in-flight writes per register = 2**CNT_W-1

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- src1  in  REG_W  first source of instruction in ID
- src2  in  REG_W  second source of instruction in ID
- two_src  in  1  src2 is a real operand
- forward_en  in  1  forwarding unit active
- issue_valid  in  1  ID instruction requests move into EXE
- issue_dest  in  REG_W  its destination register
- issue_wb_en  in  1  it writes a register
- issue_mem_r  in  1  it is a load
- flush  in  1  branch taken; squash this cycle's issue
- wb_valid  in  1  WB stage writes a register this cycle
- wb_dest  in  REG_W  WB destination
- hazard  out  1  stall ID/IF this cycle (combinational from state and query inputs)
- issue_fire  out  1  issue accepted this cycle
- busy_vec  out  NREG  bit r = pending_cnt[r] != 0
- err_overflow  out  1  sticky: issue onto saturated counter
- err_underflow  out  1  sticky: retire of register with count 0

Behaviour:
- Reset (rst_n low, async): all pending_cnt = 0, all load_flag = 0, err_* = 0. Consequently hazard = 0 and busy_vec = 0. Counting restarts from empty on release.
- Hazard when forward_en = 0:
  - src1 busy, or
  - two_src and src2 busy.
- Hazard when forward_en = 1:
  - load_flag[src1], or
  - two_src and load_flag[src2].
  - Non-load producers never stall.
- issue_fire = issue_valid & ~hazard & ~flush.
  - Only issue_fire with issue_wb_en updates state.
  - issue_wb_en = 0 fires but changes nothing.
- On issue_fire & issue_wb_en, next edge:
  - pending_cnt[issue_dest] += 1.
  - load_flag[issue_dest] = issue_mem_r.
- load_flag lifetime: every load_flag bit not set this cycle clears on the next edge. The flag therefore lives exactly one cycle: the load is in EXE, and it is forwardable from MEM afterwards.
- On wb_valid, next edge: pending_cnt[wb_dest] -= 1.
- Simultaneous issue and retire to the same register: count unchanged, load_flag still set per issue.
- Saturation at 2**CNT_W-1:
  - A further fire does not increment; sets err_overflow.
  - The issue still fires (the error is diagnostic).
- Underflow: retire at count 0 leaves 0 and sets err_underflow.
- Error flags clear only on reset.
- Latency: state updates visible one cycle after the fire/retire edge. A back-to-back dependent instruction sees the producer busy in the very next cycle.
- Same-cycle retire and query of that register: hazard still reflects the pre-edge count. WB writes the register file in the first half of the cycle, so the team accepts this conservative extra stall.
- flush with issue_valid: no state update. hazard is still computed and output normally.
- Reset mid-operation clears everything regardless of in-flight writes. The pipeline is reset alongside.

Decomposition:
- Shared package holds:
  - NREG, REG_W, CNT_W defaults
  - the saturate limit constant
  - a function decoding a REG_W index to a one-hot NREG vector, shared with the forwarding logic
- One natural sub-module: sb_counter, a single register's saturating up/down counter with overflow/underflow pulses. Instantiated NREG times via generate.
- Query muxes and hazard logic stay in the top.

Test Plan:
- Reset then query: rst_n low for 3 cycles, src1 = 3, two_src = 1, src2 = 5 -> hazard = 0, busy_vec = 0, errors 0.
- Non-forward RAW:
  - Stimulus: issue dest = 2, wb_en = 1; next cycle src1 = 2, forward_en = 0.
  - Expect: hazard = 1 and issue_fire = 0 until wb_valid with wb_dest = 2. hazard = 0 the cycle after that retire.
- Forwarding load-use:
  - Stimulus: forward_en = 1, issue load dest = 7; next cycle src2 = 7, two_src = 1.
  - Expect: hazard = 1 for exactly one cycle, then 0 with the counter still 1.
  - With two_src = 0, same stimulus -> hazard = 0.
- Saturation: three fires to dest = 4 without retire -> cnt 3, err_overflow 0; fourth fire -> err_overflow = 1, cnt stays 3.
- Simultaneous issue/retire on dest = 9 (cnt 1) -> cnt stays 1. Retire with cnt 0 on reg 10 -> err_underflow = 1.
- flush with issue_valid, dest = 1 -> issue_fire = 0, busy_vec[1] stays 0. Reset asserted with cnt[1] = 2 -> busy_vec clears asynchronously before next edge.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard and the forwarding logic.
package reg_scoreboard_pkg;
    localparam int NREG  = 16;
    localparam int REG_W = 4;
    localparam int CNT_W = 2;

    function automatic int sat_limit(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int CNT_LIMIT = sat_limit(CNT_W);

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        return NREG'(1) << idx;
    endfunction
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One register's pending-write counter: saturating up/down with error pulses.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int WIDTH = reg_scoreboard_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic ovf,
    output logic unf
);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(sat_limit(WIDTH));

    logic [WIDTH-1:0] cnt;

    // A simultaneous issue and retire cancel out, even at either bound.
    assign ovf  = inc & ~dec & (cnt == LIMIT);
    assign unf  = dec & ~inc & (cnt == '0);
    assign busy = |cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc & ~dec & ~ovf)
            cnt <= cnt + 1'b1;
        else if (dec & ~inc & ~unf)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage scoreboard: tracks in-flight register writes and raises the RAW hazard stall.
module reg_scoreboard #(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int REG_W = reg_scoreboard_pkg::REG_W,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             forward_en,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_dest,
    input  logic             issue_wb_en,
    input  logic             issue_mem_r,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_dest,
    output logic             hazard,
    output logic             issue_fire,
    output logic [NREG-1:0]  busy_vec,
    output logic             err_overflow,
    output logic             err_underflow
);
    logic [NREG-1:0] load_flag;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [NREG-1:0] ovf_vec;
    logic [NREG-1:0] unf_vec;
    logic            upd;

    // With forwarding only a load still in EXE cannot supply its result in time.
    assign hazard = forward_en
        ? (load_flag[src1] | (two_src & load_flag[src2]))
        : (busy_vec[src1]  | (two_src & busy_vec[src2]));

    assign issue_fire = issue_valid & ~hazard & ~flush;
    assign upd        = issue_fire & issue_wb_en;
    assign inc_vec    = upd      ? NREG'(reg_scoreboard_pkg::reg_onehot(issue_dest)) : '0;
    assign dec_vec    = wb_valid ? NREG'(reg_scoreboard_pkg::reg_onehot(wb_dest))    : '0;

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        sb_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_vec[g]),
            .dec   (dec_vec[g]),
            .busy  (busy_vec[g]),
            .ovf   (ovf_vec[g]),
            .unf   (unf_vec[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_flag     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            load_flag     <= issue_mem_r ? inc_vec : '0;
            err_overflow  <= err_overflow  | (|ovf_vec);
            err_underflow <= err_underflow | (|unf_vec);
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-register count model checked every cycle.
module tb_reg_scoreboard;
    localparam int NREG = 16;
    localparam int SAT  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      src1, src2, issue_dest, wb_dest;
    logic            two_src, forward_en, issue_valid, issue_wb_en, issue_mem_r, flush, wb_valid;
    logic            hazard, issue_fire, err_overflow, err_underflow;
    logic [NREG-1:0] busy_vec;

    int checks = 0;
    int errors = 0;

    int mcnt[NREG];
    bit mload[NREG];
    bit movf, munf;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .two_src(two_src),
        .forward_en(forward_en), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_wb_en(issue_wb_en), .issue_mem_r(issue_mem_r), .flush(flush),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .hazard(hazard), .issue_fire(issue_fire),
        .busy_vec(busy_vec), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        if (forward_en)
            return mload[src1] || (two_src && mload[src2]);
        return (mcnt[src1] != 0) || (two_src && (mcnt[src2] != 0));
    endfunction

    // Model: counts per register, load flag lives one cycle, sticky errors.
    always @(posedge clk or negedge rst_n) begin : mdl
        automatic int nc[NREG];
        automatic bit nl[NREG];
        automatic bit up;
        if (!rst_n) begin
            foreach (nc[i]) begin nc[i] = 0; nl[i] = 0; end
            mcnt <= nc; mload <= nl; movf <= 0; munf <= 0;
        end else begin
            nc = mcnt;
            foreach (nl[i]) nl[i] = 0;
            up = issue_valid && !m_hazard() && !flush && issue_wb_en;
            if (up) nl[issue_dest] = issue_mem_r;
            if (!(up && wb_valid && issue_dest == wb_dest)) begin
                if (up) begin
                    if (nc[issue_dest] == SAT) movf <= 1;
                    else nc[issue_dest] = nc[issue_dest] + 1;
                end
                if (wb_valid) begin
                    if (nc[wb_dest] == 0) munf <= 1;
                    else nc[wb_dest] = nc[wb_dest] - 1;
                end
            end
            mcnt <= nc; mload <= nl;
        end
    end

    always @(negedge clk) begin : cmp
        automatic bit eh;
        automatic logic [NREG-1:0] eb;
        eh = m_hazard();
        for (int i = 0; i < NREG; i++) eb[i] = (mcnt[i] != 0);
        chk("cyc_hazard", hazard, eh);
        chk("cyc_issue_fire", issue_fire, issue_valid && !eh && !flush);
        chk("cyc_busy_vec", busy_vec, eb);
        chk("cyc_err_overflow", err_overflow, movf);
        chk("cyc_err_underflow", err_underflow, munf);
    end

    task automatic idle();
        src1 = 0; src2 = 0; two_src = 0; forward_en = 0; issue_valid = 0; issue_dest = 0;
        issue_wb_en = 0; issue_mem_r = 0; flush = 0; wb_valid = 0; wb_dest = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] d, input logic ld);
        issue_valid = 1; issue_dest = d; issue_wb_en = 1; issue_mem_r = ld;
    endtask

    initial begin
        rst_n = 0; idle(); src1 = 3; src2 = 5; two_src = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hazard", hazard, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_errs", {err_overflow, err_underflow}, 0);
        rst_n = 1; step();

        // Non-forwarding RAW on r2
        idle(); issue(2, 0); #1;
        chk("raw_fire0", issue_fire, 1); step();
        idle(); src1 = 2; issue(3, 0); #1;
        chk("raw_haz1", hazard, 1); chk("raw_nofire", issue_fire, 0); step();
        #1 chk("raw_haz2", hazard, 1); step();
        wb_valid = 1; wb_dest = 2; #1;
        chk("raw_haz_retire", hazard, 1); step();
        wb_valid = 0; #1;
        chk("raw_clear", hazard, 0); chk("raw_fire1", issue_fire, 1); step();
        idle(); wb_valid = 1; wb_dest = 3; step();

        // Forwarding load-use on r7
        idle(); forward_en = 1; issue(7, 1); step();
        idle(); forward_en = 1; src2 = 7; two_src = 1; issue_valid = 1; #1;
        chk("lu_haz", hazard, 1); step();
        #1 chk("lu_haz_clr", hazard, 0); chk("lu_busy7", busy_vec[7], 1); step();
        idle(); forward_en = 1; issue(7, 1); step();
        idle(); forward_en = 1; src2 = 7; two_src = 0; issue_valid = 1; #1;
        chk("lu_one_src", hazard, 0); step();
        idle(); wb_valid = 1; wb_dest = 7; step(); step();
        idle(); #1 chk("lu_drained", busy_vec[7], 0);

        // Saturation on r4
        forward_en = 1; issue(4, 0); repeat (3) step();
        #1 chk("sat_busy", busy_vec[4], 1); chk("sat_ovf0", err_overflow, 0); step();
        #1 chk("sat_ovf1", err_overflow, 1);
        idle(); wb_valid = 1; wb_dest = 4; step(); step();
        #1 chk("sat_after2", busy_vec[4], 1); step();
        #1 chk("sat_drained", busy_vec[4], 0); chk("sat_no_unf", err_underflow, 0);

        // Simultaneous issue/retire on r9, underflow on r10
        idle(); forward_en = 1; issue(9, 0); step();
        wb_valid = 1; wb_dest = 9; step();
        idle(); #1 chk("sim_busy9", busy_vec[9], 1);
        wb_valid = 1; wb_dest = 9; step();
        idle(); #1 chk("sim_cleared9", busy_vec[9], 0); chk("sim_no_unf", err_underflow, 0);
        wb_valid = 1; wb_dest = 10; step();
        idle(); #1 chk("unf_set", err_underflow, 1); chk("unf_busy10", busy_vec[10], 0);

        // Flush, then async reset with r1 in flight
        issue(1, 0); flush = 1; #1;
        chk("flush_nofire", issue_fire, 0); step();
        idle(); #1 chk("flush_busy1", busy_vec[1], 0);
        issue(1, 0); step(); step();
        idle(); #1 chk("pre_rst_busy1", busy_vec[1], 1);
        rst_n = 0; #1;
        chk("async_rst_busy", busy_vec, 0);
        chk("async_rst_errs", {err_overflow, err_underflow}, 0);
        step(); step();
        rst_n = 1; step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
